tape_punch: RTL and testbench

- Simulation model of the G-15 paper-tape punch: the write-side counterpart of the phototape reader model in the power-up bench.
- Watches PUNCH_SIGNAL from g15_top and, while it is asserted, runs a motor spin-up and then a character-rate PUNCH_SYNC pulse train.
- Samples the 5-bit punch code at each sync and captures the characters in an internal FIFO.
- The bench drains the FIFO to compare punched output against expected tape images.

---
 rtl/tape_punch.sv | 195 +++++++++++++++++++
 tb/tb_tape_punch.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tape_punch.sv
// -----------------------------------------------------------------------------
// tape_punch -- simulation model of the G-15 paper-tape punch.
//
// While PUNCH_SIGNAL is high the model spins up the punch motor for
// SPINUP_TICKS timebase ticks. It then emits one PUNCH_SYNC pulse per
// character, spaced CHAR_TICKS ticks apart. On the last clock of each sync
// pulse it samples punch_code into a capture FIFO, which the bench drains
// to compare against expected tape images.
//
// Optional feature (compile-time macro TAPE_PUNCH_LEADER_SKIP_EN):
//   When defined, blank leader codes (5'b00000) sampled after each motor
//   start are neither stored nor counted until the first nonzero code.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   tick          one-clock timebase pulse (tick_ms)
//   PUNCH_SIGNAL  computer requests punching
//   punch_code    code bits 1..5 (bit0 = channel 1)
//   PUNCH_SYNC    registered per-character sync back to the computer
//   rd_en         pop one FIFO entry (ignored while empty)
//   rd_data       FIFO head, valid when !empty (0 when empty)
//   empty         FIFO empty
//   count         entries held, 0..DEPTH
//   punched_total characters accepted since reset, saturating
//   overflow      sticky: a character was dropped because the FIFO was full
//   busy          FSM not in IDLE
// -----------------------------------------------------------------------------
module tape_punch #(
  parameter int SPINUP_TICKS = 30,
  parameter int CHAR_TICKS   = 59,
  parameter int SYNC_WIDTH   = 16,
  parameter int DEPTH        = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     PUNCH_SIGNAL,
  input  logic [4:0]               punch_code,
  output logic                     PUNCH_SYNC,
  input  logic                     rd_en,
  output logic [4:0]               rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              punched_total,
  output logic                     overflow,
  output logic                     busy
);

  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;
  localparam int TMAX_RAW = (SPINUP_TICKS > CHAR_TICKS) ? SPINUP_TICKS : CHAR_TICKS;
  localparam int TMAX     = (TMAX_RAW < 1) ? 1 : TMAX_RAW;
  localparam int TW       = $clog2(TMAX + 1);
  localparam int SMAX     = (SYNC_WIDTH < 1) ? 1 : SYNC_WIDTH;
  localparam int SW       = $clog2(SMAX + 1);

  localparam logic [TW-1:0] SPIN_LOAD = TW'(SPINUP_TICKS);
  localparam logic [TW-1:0] CHAR_LOAD = TW'(CHAR_TICKS);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SMAX);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, SPINUP, WAIT, SYNC, STOPPING} state_t;

  state_t          state, state_next;
  logic [TW-1:0]   tick_cnt, tick_cnt_next;
  logic [SW-1:0]   sync_cnt;
  logic            sync_last;
  logic            timer_done;
  logic            sample;
  logic            store_ok;
  logic            wr_req, wr_accept, do_read, full;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [4:0]      mem [DEPTH];

  // The state entered SYNC on the clock where sync_cnt was 0, so a count of
  // SYNC_WIDTH marks the last of SYNC_WIDTH+1 state clocks; PUNCH_SYNC is
  // high on the final SYNC_WIDTH of them.
  assign sync_last  = (state == SYNC) && (sync_cnt == SYNC_LAST);
  assign timer_done = (tick_cnt == '0) || (tick && (tick_cnt == TW'(1)));

  // NOTE: every variable of a combinational block gets a default before the
  // case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    tick_cnt_next = tick_cnt;
    sample        = 1'b0;
    unique case (state)
      IDLE: begin
        if (PUNCH_SIGNAL) begin
          state_next    = SPINUP;
          tick_cnt_next = SPIN_LOAD;
        end
      end
      SPINUP, WAIT: begin
        if (!PUNCH_SIGNAL) begin
          // A drop before the first sync punches nothing; a drop between
          // characters still passes through STOPPING.
          state_next = (state == SPINUP) ? IDLE : STOPPING;
        end else if (timer_done) begin
          state_next = SYNC;
        end else if (tick) begin
          tick_cnt_next = tick_cnt - TW'(1);
        end
      end
      SYNC: begin
        if (sync_last) begin
          sample = 1'b1;
          if (PUNCH_SIGNAL) begin
            state_next    = WAIT;
            tick_cnt_next = CHAR_LOAD;
          end else begin
            state_next = STOPPING;
          end
        end
      end
      STOPPING: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      sync_cnt   <= '0;
      PUNCH_SYNC <= 1'b0;
    end else begin
      state      <= state_next;
      tick_cnt   <= tick_cnt_next;
      sync_cnt   <= ((state == SYNC) && !sync_last) ? sync_cnt + SW'(1) : '0;
      PUNCH_SYNC <= (state == SYNC) && !sync_last;
    end
  end

`ifdef TAPE_PUNCH_LEADER_SKIP_EN
  // Armed at every motor start, disarmed by the first nonzero code.
  logic leader_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      leader_q <= 1'b0;
    end else if ((state == IDLE) && PUNCH_SIGNAL) begin
      leader_q <= 1'b1;
    end else if (sample && (punch_code != 5'd0)) begin
      leader_q <= 1'b0;
    end
  end

  assign store_ok = !(leader_q && (punch_code == 5'd0));
`else
  assign store_ok = 1'b1;
`endif

  assign wr_req    = sample && store_ok;
  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign do_read   = rd_en && !empty;
  // A read in the same clock frees the slot, so a full FIFO still accepts.
  assign wr_accept = wr_req && (!full || do_read);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      punched_total <= '0;
      overflow      <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + AW'(1);
      if (do_read)   rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_accept, do_read})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_accept && (punched_total != 16'hFFFF))
        punched_total <= punched_total + 16'd1;
      if (wr_req && !wr_accept)
        overflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define
  // which entries are valid, and rd_data is forced to 0 while empty.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= punch_code;
  end

  assign rd_data = empty ? 5'd0 : mem[rd_ptr];
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_tape_punch.sv
// -----------------------------------------------------------------------------
// tb_tape_punch -- directed self-checking bench for tape_punch.
// Uses small timing parameters (spin-up 2 ticks, 3 ticks per character,
// 4-clock sync, 4-entry FIFO). Inputs are driven and outputs sampled on the
// falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_tape_punch;

  localparam int SPIN = 2;
  localparam int CHR  = 3;
  localparam int SW   = 4;
  localparam int DEP  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        PUNCH_SIGNAL;
  logic [4:0]  punch_code;
  logic        PUNCH_SYNC;
  logic        rd_en;
  logic [4:0]  rd_data;
  logic        empty;
  logic [$clog2(DEP):0] count;
  logic [15:0] punched_total;
  logic        overflow;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tape_punch #(
    .SPINUP_TICKS(SPIN),
    .CHAR_TICKS  (CHR),
    .SYNC_WIDTH  (SW),
    .DEPTH       (DEP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .PUNCH_SIGNAL (PUNCH_SIGNAL),
    .punch_code   (punch_code),
    .PUNCH_SYNC   (PUNCH_SYNC),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .count        (count),
    .punched_total(punched_total),
    .overflow     (overflow),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  // Waits (bounded) for PUNCH_SYNC to be high, then counts its high clocks.
  // Returns on the first low sample after the pulse; w=0 if it never rose.
  task automatic wait_sync(output int w);
    int guard;
    guard = 0;
    w = 0;
    while (PUNCH_SYNC !== 1'b1 && guard < 12) begin
      @(negedge clk);
      guard++;
    end
    while (PUNCH_SYNC === 1'b1 && w < 20) begin
      w++;
      @(negedge clk);
    end
  endtask

  task automatic punch_char(input logic [4:0] code, input int n_ticks, input string tag);
    int w;
    punch_code = code;
    ticks(n_ticks);
    wait_sync(w);
    check(tag, w, SW);
  endtask

  task automatic pop(output logic [4:0] d);
    d = rd_data;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] d;
    logic [4:0] lead_exp[$];
    int         w;
    int         seen;
    int         guard;

    rst          = 1'b1;
    tick         = 1'b0;
    PUNCH_SIGNAL = 1'b0;
    punch_code   = 5'd0;
    rd_en        = 1'b0;

    // Reset held 3 clocks while the request line toggles and ticks arrive.
    for (int i = 0; i < 3; i++) begin
      PUNCH_SIGNAL = (i % 2 == 0);
      tick         = 1'b1;
      @(negedge clk);
    end
    rst          = 1'b0;
    tick         = 1'b0;
    PUNCH_SIGNAL = 1'b0;
    check("rst_sync",     PUNCH_SYNC,    0);
    check("rst_empty",    empty,         1);
    check("rst_count",    count,         0);
    check("rst_busy",     busy,          0);
    check("rst_overflow", overflow,      0);
    check("rst_total",    punched_total, 0);
    check("rst_rd_data",  rd_data,       0);
    step(1);
    check("rst_idle_after", busy, 0);

    // Single character, request dropped during the sync pulse.
    punch_code   = 5'h13;
    PUNCH_SIGNAL = 1'b1;
    step(1);
    check("single_busy", busy, 1);
    ticks(SPIN);
    check("single_sync_low_on_entry", PUNCH_SYNC, 0);
    step(1);
    check("single_sync_rise", PUNCH_SYNC, 1);
    PUNCH_SIGNAL = 1'b0;
    wait_sync(w);
    check("single_sync_width", w, SW);
    check("single_count",   count,         1);
    check("single_rd_data", rd_data,       5'h13);
    check("single_total",   punched_total, 1);
    check("single_stopping_busy", busy,    1);
    step(1);
    check("single_idle", busy, 0);
    pop(d);
    check("single_pop", d, 5'h13);
    check("single_empty_after_pop", empty, 1);

    // Burst of three; the tick coincident with motor start is not counted.
    punch_code   = 5'h01;
    PUNCH_SIGNAL = 1'b1;
    tick         = 1'b1;
    step(1);
    tick         = 1'b0;
    ticks(1);
    step(2);
    check("burst_entry_tick_ignored", PUNCH_SYNC, 0);
    punch_char(5'h01, 1,   "burst_w1");
    punch_char(5'h02, CHR, "burst_w2");
    punch_char(5'h03, CHR, "burst_w3");
    ticks(1);
    PUNCH_SIGNAL = 1'b0;
    step(1);
    check("burst_stopping", busy, 1);
    step(1);
    check("burst_idle", busy, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      if (PUNCH_SYNC === 1'b1) seen++;
    end
    check("burst_no_4th_sync", seen, 0);
    check("burst_count", count, 3);
    check("burst_total", punched_total, 4);
    pop(d); check("burst_pop1", d, 5'h01);
    pop(d); check("burst_pop2", d, 5'h02);
    pop(d); check("burst_pop3", d, 5'h03);
    check("burst_empty", empty, 1);

    // Overflow: five characters into four slots, then a read coinciding
    // with the sixth write.
    punch_code   = 5'h11;
    PUNCH_SIGNAL = 1'b1;
    step(1);
    punch_char(5'h11, SPIN, "ovf_w1");
    punch_char(5'h12, CHR,  "ovf_w2");
    punch_char(5'h13, CHR,  "ovf_w3");
    check("ovf_no_flag_yet", overflow, 0);
    punch_char(5'h14, CHR,  "ovf_w4");
    punch_char(5'h15, CHR,  "ovf_w5");
    check("ovf_count",    count,         4);
    check("ovf_flag",     overflow,      1);
    check("ovf_total",    punched_total, 8);
    punch_code = 5'h16;
    ticks(CHR);
    guard = 0;
    while (PUNCH_SYNC !== 1'b1 && guard < 12) begin
      @(negedge clk);
      guard++;
    end
    check("ovf6_sync_seen", PUNCH_SYNC, 1);
    step(SW - 1);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    check("ovf6_count",  count,         4);
    check("ovf6_total",  punched_total, 9);
    check("ovf6_flag",   overflow,      1);
    PUNCH_SIGNAL = 1'b0;
    step(2);
    pop(d); check("ovf_pop1", d, 5'h12);
    pop(d); check("ovf_pop2", d, 5'h13);
    check("ovf_count_after_pops", count, 2);

    // Reset in the middle of a sync pulse, with two entries still queued.
    punch_code   = 5'h0A;
    PUNCH_SIGNAL = 1'b1;
    step(1);
    ticks(SPIN);
    step(2);
    check("mrst_in_sync", PUNCH_SYNC, 1);
    rst          = 1'b1;
    PUNCH_SIGNAL = 1'b0;
    step(1);
    rst = 1'b0;
    check("mrst_sync",     PUNCH_SYNC,    0);
    check("mrst_empty",    empty,         1);
    check("mrst_count",    count,         0);
    check("mrst_busy",     busy,          0);
    check("mrst_overflow", overflow,      0);
    check("mrst_total",    punched_total, 0);
    ticks(4);
    step(4);
    check("mrst_char_absent", count, 0);
    check("mrst_total_after", punched_total, 0);

    // Leader codes: 00, 00, 07, 00 in one continuous run.
`ifdef TAPE_PUNCH_LEADER_SKIP_EN
    lead_exp = '{5'h07, 5'h00};
`else
    lead_exp = '{5'h00, 5'h00, 5'h07, 5'h00};
`endif
    punch_code   = 5'h00;
    PUNCH_SIGNAL = 1'b1;
    step(1);
    punch_char(5'h00, SPIN, "lead_w1");
    punch_char(5'h00, CHR,  "lead_w2");
    punch_char(5'h07, CHR,  "lead_w3");
    punch_char(5'h00, CHR,  "lead_w4");
    PUNCH_SIGNAL = 1'b0;
    step(2);
    check("lead_count", count,         lead_exp.size());
    check("lead_total", punched_total, lead_exp.size());
    foreach (lead_exp[i]) begin
      pop(d);
      check($sformatf("lead_pop%0d", i), d, lead_exp[i]);
    end
    check("lead_empty", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
